// File: rtl/regfile_alu_slice.sv
// Execution slice: 32x32 register file (2 async reads, 1 sync write), 16->32 sign
// extender and a 32-bit combinational ALU with shift and compare groups.
module regfile_alu_slice (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rw,
  input  logic [31:0] busw,
  input  logic        regwr,
  output logic [31:0] busa,
  output logic [31:0] busb,
  input  logic [15:0] imm16,
  output logic [31:0] ext_imm,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [5:0]  alu_ctl,
  output logic [31:0] alu_out,
  output logic        a_zero
);

  // r0 has no storage; it is hardwired to zero on both read ports
  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (regwr && rw != 5'd0) begin
      regs[rw] <= busw;
    end
  end

  assign busa   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign busb   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign a_zero = (busa == 32'd0);

  assign ext_imm = {{16{imm16[15]}}, imm16};

  logic [4:0]  shAmt;
  logic        sLt, uLt, isEq;
  logic        cmpRes;
  logic [31:0] aluRes;

  assign shAmt = alu_b[4:0];
  assign sLt   = $signed(alu_a) < $signed(alu_b);
  assign uLt   = alu_a < alu_b;
  assign isEq  = alu_a == alu_b;

  always_comb begin
    aluRes = '0;
    cmpRes = 1'b0;
    case (alu_ctl)
      6'b000000: aluRes = alu_a + alu_b;
      6'b000001: aluRes = alu_a - alu_b;
      6'b000010: aluRes = alu_a & alu_b;
      6'b000011: aluRes = alu_a | alu_b;
      6'b001000: aluRes = alu_a ^ alu_b;
      6'b000100: aluRes = alu_a << shAmt;
      6'b000101: aluRes = alu_a >> shAmt;
      6'b000110: aluRes = $signed(alu_a) >>> shAmt;
      6'b100000: begin cmpRes = isEq;          aluRes = {31'd0, cmpRes}; end
      6'b100001: begin cmpRes = !isEq;         aluRes = {31'd0, cmpRes}; end
      6'b100010: begin cmpRes = sLt;           aluRes = {31'd0, cmpRes}; end
      6'b100011: begin cmpRes = !sLt && !isEq; aluRes = {31'd0, cmpRes}; end
      6'b100100: begin cmpRes = sLt || isEq;   aluRes = {31'd0, cmpRes}; end
      6'b100101: begin cmpRes = !sLt;          aluRes = {31'd0, cmpRes}; end
      6'b110010: begin cmpRes = uLt;           aluRes = {31'd0, cmpRes}; end
      6'b110011: begin cmpRes = !uLt && !isEq; aluRes = {31'd0, cmpRes}; end
      6'b110100: begin cmpRes = uLt || isEq;   aluRes = {31'd0, cmpRes}; end
      6'b110101: begin cmpRes = !uLt;          aluRes = {31'd0, cmpRes}; end
      default:   aluRes = '0;
    endcase
  end

  assign alu_out = aluRes;

endmodule

// File: tb/tb_regfile_alu_slice.sv
// Self-checking bench for regfile_alu_slice: directed vectors, hand-written
// register-file sequences and randomized traffic against a reference model.
module tb_regfile_alu_slice;

  logic        clk = 1'b0;
  logic        reset, regwr;
  logic [4:0]  rs1, rs2, rw;
  logic [31:0] busw, busa, busb, ext_imm, alu_a, alu_b, alu_out;
  logic [15:0] imm16;
  logic [5:0]  alu_ctl;
  logic        a_zero;

  int tests = 0;
  int failed = 0;

  regfile_alu_slice dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rw(rw), .busw(busw),
    .regwr(regwr), .busa(busa), .busb(busb), .imm16(imm16), .ext_imm(ext_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_out(alu_out),
    .a_zero(a_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } aluVec_t;

  aluVec_t     vecs[$];
  logic [31:0] mdl [32];
  logic [5:0]  validCodes [18] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011,
    6'b001000, 6'b000100, 6'b000101, 6'b000110, 6'b100000, 6'b100001, 6'b100010,
    6'b100011, 6'b100100, 6'b100101, 6'b110010, 6'b110011, 6'b110100, 6'b110101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU straight from the operation table
  function automatic logic [31:0] aluModel(input logic [5:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
    int sa, sb;
    longint unsigned ua, ub;
    logic [63:0] wide;
    int n;
    sa = a; sb = b; ua = a; ub = b; n = b % 32;
    case (c)
      6'b000000: return 32'((ua + ub) % 64'h1_0000_0000);
      6'b000001: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      6'b000010: return a & b;
      6'b000011: return a | b;
      6'b001000: return a ^ b;
      6'b000100: return 32'((ua * (64'd1 << n)) % 64'h1_0000_0000);
      6'b000101: return 32'(ua / (64'd1 << n));
      6'b000110: begin wide = {{32{a[31]}}, a}; return wide[n +: 32]; end
      6'b100000: return (a == b) ? 1 : 0;
      6'b100001: return (a != b) ? 1 : 0;
      6'b100010: return (sa <  sb) ? 1 : 0;
      6'b100011: return (sa >  sb) ? 1 : 0;
      6'b100100: return (sa <= sb) ? 1 : 0;
      6'b100101: return (sa >= sb) ? 1 : 0;
      6'b110010: return (ua <  ub) ? 1 : 0;
      6'b110011: return (ua >  ub) ? 1 : 0;
      6'b110100: return (ua <= ub) ? 1 : 0;
      6'b110101: return (ua >= ub) ? 1 : 0;
      default:   return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; regwr = 1'b0; rs1 = '0; rs2 = '0; rw = '0; busw = '0;
    imm16 = '0; alu_a = '0; alu_b = '0; alu_ctl = '0;

    // 1. reset clears every register
    @(negedge clk); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); #1;
      chk($sformatf("reset_busa[%0d]", i), busa, 32'd0);
      chk($sformatf("reset_busb[%0d]", 31 - i), busb, 32'd0);
      chk($sformatf("reset_azero[%0d]", i), {31'd0, a_zero}, 32'd1);
    end

    // 2. writes, r0 discard, read-during-write, write disable, reset priority
    @(negedge clk); regwr = 1'b1; rw = 5'd5; busw = 32'hDEADBEEF; tick();
    @(negedge clk); rw = 5'd0; busw = 32'h12345678; tick();
    @(negedge clk); regwr = 1'b0; rs1 = 5'd5; rs2 = 5'd0; #1;
    chk("wr_r5", busa, 32'hDEADBEEF);
    chk("wr_r0_discard", busb, 32'd0);
    chk("azero_nonzero", {31'd0, a_zero}, 32'd0);
    @(negedge clk); regwr = 1'b1; rw = 5'd5; busw = 32'd1; #1;
    chk("rdw_before_edge", busa, 32'hDEADBEEF);
    tick();
    chk("rdw_after_edge", busa, 32'd1);
    @(negedge clk); regwr = 1'b0; busw = 32'h77; tick();
    chk("regwr0_nochange", busa, 32'd1);
    @(negedge clk); reset = 1'b1; regwr = 1'b1; busw = 32'hAAAA5555; tick();
    reset = 1'b0; regwr = 1'b0;
    chk("reset_over_write", busa, 32'd0);
    chk("reset_azero", {31'd0, a_zero}, 32'd1);

    // 3. sign extender boundaries
    imm16 = 16'h7FFF; #1; chk("ext_7fff", ext_imm, 32'h00007FFF);
    imm16 = 16'h8000; #1; chk("ext_8000", ext_imm, 32'hFFFF8000);
    imm16 = 16'hFFFF; #1; chk("ext_ffff", ext_imm, 32'hFFFFFFFF);

    // 4-6. ALU directed table
    vecs.push_back('{6'b000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{6'b000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{6'b000010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    vecs.push_back('{6'b000011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0});
    vecs.push_back('{6'b001000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0});
    vecs.push_back('{6'b000100, 32'h80000001, 32'h00000004, 32'h00000010});
    vecs.push_back('{6'b000101, 32'h80000001, 32'h00000004, 32'h08000000});
    vecs.push_back('{6'b000110, 32'h80000001, 32'h00000004, 32'hF8000000});
    vecs.push_back('{6'b000100, 32'h80000001, 32'h00000024, 32'h00000010});
    vecs.push_back('{6'b100010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{6'b110010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{6'b100011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{6'b110011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{6'b110100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{6'b110101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    vecs.push_back('{6'b100000, 32'h00000005, 32'h00000005, 32'h00000001});
    vecs.push_back('{6'b100001, 32'h00000005, 32'h00000005, 32'h00000000});
    vecs.push_back('{6'b100100, 32'h00000005, 32'h00000005, 32'h00000001});
    vecs.push_back('{6'b100101, 32'h00000005, 32'h00000005, 32'h00000001});
    vecs.push_back('{6'b111111, 32'h12345678, 32'h00000001, 32'h00000000});
    vecs.push_back('{6'b000111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    foreach (vecs[i]) begin
      alu_ctl = vecs[i].ctl; alu_a = vecs[i].a; alu_b = vecs[i].b; #1;
      chk($sformatf("alu_vec[%0d] ctl=%b", i, vecs[i].ctl), alu_out, vecs[i].exp);
    end

    // Random ALU and sign extender against the model
    for (int i = 0; i < 400; i++) begin
      alu_ctl = ($urandom_range(0, 3) != 0) ? validCodes[$urandom_range(0, 17)]
                                            : 6'($urandom);
      alu_a = $urandom;
      alu_b = ($urandom_range(0, 7) == 0) ? alu_a : $urandom;
      imm16 = 16'($urandom);
      #1;
      chk($sformatf("alu_rand ctl=%b a=%h b=%h", alu_ctl, alu_a, alu_b), alu_out,
          aluModel(alu_ctl, alu_a, alu_b));
      chk("ext_rand", ext_imm, imm16[15] ? (32'hFFFF0000 | 32'(imm16)) : 32'(imm16));
    end

    // Random register-file traffic against an array model
    @(negedge clk); reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 49) == 0);
      regwr = $urandom_range(0, 1);
      rw = 5'($urandom_range(0, 7) == 0 ? 0 : $urandom);
      busw = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
      rs2 = 5'($urandom);
      #1;
      chk("rf_pre_busa", busa, mdl[rs1]);
      chk("rf_pre_busb", busb, mdl[rs2]);
      chk("rf_pre_azero", {31'd0, a_zero}, (mdl[rs1] == 0) ? 32'd1 : 32'd0);
      @(posedge clk);
      if (reset) for (int k = 0; k < 32; k++) mdl[k] = '0;
      else if (regwr && rw != 0) mdl[rw] = busw;
      #1;
      chk("rf_post_busa", busa, mdl[rs1]);
      chk("rf_post_busb", busb, mdl[rs2]);
    end
    reset = 1'b0; regwr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_alu_slice.md
Name: regfile_alu_slice

Overview:
Execution slice of the single-cycle processor datapath. It bundles three independent sub-functions:
- a 32x32 register file with two asynchronous read ports and one synchronous write port;
- a 16-to-32 sign extender;
- a 32-bit combinational ALU driven by six one-hot-free control bits.

The surrounding datapath supplies operand muxing, data memory and write-back selection.

Parameters:
None. Data width is fixed at 32 and register count at 32; neither is configurable.

Ports:
clk      in   1   single clock; all state updates on rising edge
reset    in   1   synchronous, active-high; clears every register on the rising edge of clk
rs1      in   5   read address port A
rs2      in   5   read address port B
rw       in   5   write address
busw     in   32  write data
regwr    in   1   write enable
busa     out  32  read data port A (regs[rs1])
busb     out  32  read data port B (regs[rs2])
imm16    in   16  immediate to extend
ext_imm  out  32  sign-extended imm16
alu_a    in   32  ALU operand A
alu_b    in   32  ALU operand B
alu_ctl  in   6   {alu5,alu4,alu3,alu2,alu1,alu0}
alu_out  out  32  ALU result
a_zero   out  1   1 when busa == 0 (branch zero flag)

Behaviour:

Register file:
- Reads are combinational: busa = regs[rs1], busb = regs[rs2]. Register 0 always reads 0.
- Write: on posedge clk, if regwr=1 and rw!=0, then regs[rw] <= busw. Writes to register 0 are discarded.
- Reset: on posedge clk with reset=1, all 32 registers become 0. Reset has priority over a simultaneous write.
- After reset, busa and busb are 0 for every address.
- Read during write to the same address: the read returns the old value until the edge, and the new value immediately after it (no bypass).

Sign extender:
- ext_imm = {16{imm16[15]}, imm16}. Purely combinational, no latency.

ALU:
- Combinational, no latency.
- Operation selected by alu_ctl (binary, MSB first):
  - 000000 ADD: a+b, modulo 2^32, no overflow trap.
  - 000001 SUB: a-b, modulo 2^32.
  - 000010 AND.
  - 000011 OR.
  - 001000 XOR.
  - 000100 SLL: a << b[4:0].
  - 000101 SRL: logical shift right.
  - 000110 SRA: arithmetic shift right.
    - Shifts use only b[4:0]; b[31:5] is ignored.
  - 100000 SEQ, 100001 SNE.
  - 100010 SLT, 100011 SGT, 100100 SLE, 100101 SGE: signed two's-complement compares.
  - 110010 SLTU, 110011 SGTU, 110100 SLEU, 110101 SGEU: unsigned compares.
    - All compares yield 32'h00000001 if true, 32'h00000000 if false.
  - Any other code: alu_out = 0.
- Group decode rules the datapath relies on:
  - alu2=1 with alu5=0 is always a shift;
  - alu5=1 is always a compare.

Flags:
- a_zero = (busa == 0); it follows reads combinationally.

Timing:
- No outputs other than register contents are registered.
- No X propagates from unwritten registers, because reset initialises them all.

Test Plan:
1. Assert reset for one edge, then read all 32 addresses on both ports -> all 0; a_zero=1.
2. Write 32'hDEADBEEF to r5 (regwr=1) and 32'h12345678 to r0 -> rs1=5 gives DEADBEEF, rs2=0 gives 0.
   - Same cycle rs1=5, rw=5, busw=1: busa stays DEADBEEF before the edge and becomes 1 after it.
   - regwr=0 with rw=5: no change.
   - reset with regwr=1 simultaneously: r5 becomes 0.
3. imm16=16'h7FFF -> ext_imm=32'h00007FFF; imm16=16'h8000 -> ext_imm=32'hFFFF8000; imm16=16'hFFFF -> ext_imm=32'hFFFFFFFF.
4. ALU arithmetic/logic:
   - ADD FFFFFFFF+1 -> 0.
   - SUB 0-1 -> FFFFFFFF.
   - AND/OR/XOR on F0F0F0F0 and FF00FF00 -> F000F000 / FFF0FFF0 / 0FF00FF0.
5. Shifts with a=80000001:
   - SLL b=4 -> 00000010.
   - SRL b=4 -> 08000000.
   - SRA b=4 -> F8000000.
   - SLL b=32'h00000024 -> uses b[4:0]=4, result 00000010.
6. Compares with a=FFFFFFFF, b=1:
   - SLT -> 1, SLTU -> 0, SGT -> 0, SGTU -> 1.
   - SEQ a=b=5 -> 1, SNE -> 0, SLE and SGE -> 1.
   - Undefined code 111111 -> 0.
